// File: rtl/output_io_port.sv
// Memory-mapped LED/HEX/LCD output peripheral with readback and a multiplexed 7-segment scanner.
// Optional HEX_DECODE_EN: HEX bytes hold nibble values decoded to glyphs instead of raw segments.
module output_io_port #(
   parameter int SCAN_DIV   = 1000,
   parameter int NUM_DIGITS = 8
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [31:0]           i_lsu_addr,
   input  logic [31:0]           i_lsu_wdata,
   input  logic                  i_lsu_wren,
   input  logic [3:0]            i_lsu_bmask,
   output logic [31:0]           o_io_rdata,
   output logic [31:0]           o_io_ledr,
   output logic [31:0]           o_io_ledg,
   output logic [31:0]           o_io_lcd,
   output logic [6:0]            o_io_hex,
   output logic [NUM_DIGITS-1:0] o_io_an
);

   localparam int PRE_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
   localparam logic [2:0] IDX_LAST = 3'(NUM_DIGITS - 1);

   localparam logic [19:0] PAGE_LEDR = 20'h10000;
   localparam logic [19:0] PAGE_LEDG = 20'h10001;
   localparam logic [19:0] PAGE_HEXL = 20'h10002;
   localparam logic [19:0] PAGE_HEXH = 20'h10003;
   localparam logic [19:0] PAGE_LCD  = 20'h10004;

   typedef enum logic {BLANK = 1'b0, ACTIVE = 1'b1} scan_state_t;

   logic [31:0]      ledr_r, ledg_r, lcd_r, hex_lo_r, hex_hi_r, rdata_r;
   logic             armed_r;
   logic [PRE_W-1:0] pre_r;
   logic [2:0]       idx_r;
   scan_state_t      state_r, state_s;
   logic [19:0]      page_s;
   logic             wr_s;
   logic [63:0]      hex_all_s;
   logic [7:0]       digit_byte_s;
   logic [6:0]       seg_s;
   logic             pre_wrap_s;
   logic             unused_s;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  mask);
      logic [31:0] res;
      res = old_v;
      for (int b = 0; b < 4; b++) begin
         if (mask[b]) res[8*b +: 8] = new_v[8*b +: 8];
      end
      return res;
   endfunction

   // Active-low glyphs, bit0 = segment a.
   function automatic logic [6:0] hex_glyph(input logic [3:0] v);
      case (v)
         4'h0: hex_glyph = 7'h40;  4'h1: hex_glyph = 7'h79;
         4'h2: hex_glyph = 7'h24;  4'h3: hex_glyph = 7'h30;
         4'h4: hex_glyph = 7'h19;  4'h5: hex_glyph = 7'h12;
         4'h6: hex_glyph = 7'h02;  4'h7: hex_glyph = 7'h78;
         4'h8: hex_glyph = 7'h00;  4'h9: hex_glyph = 7'h10;
         4'hA: hex_glyph = 7'h08;  4'hB: hex_glyph = 7'h03;
         4'hC: hex_glyph = 7'h46;  4'hD: hex_glyph = 7'h21;
         4'hE: hex_glyph = 7'h06;  4'hF: hex_glyph = 7'h0E;
         default: hex_glyph = 7'h7F;
      endcase
   endfunction

   assign page_s = i_lsu_addr[31:12];
   assign wr_s   = i_lsu_wren & armed_r;

   // Stores are held off until the first edge after reset release.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) armed_r <= 1'b0;
      else          armed_r <= 1'b1;
   end

   // Byte-lane register writes.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         ledr_r   <= 32'h0;
         ledg_r   <= 32'h0;
         lcd_r    <= 32'h0;
         hex_lo_r <= 32'h0;
         hex_hi_r <= 32'h0;
      end else if (wr_s) begin
         case (page_s)
            PAGE_LEDR: ledr_r   <= merge_bytes(ledr_r,   i_lsu_wdata, i_lsu_bmask);
            PAGE_LEDG: ledg_r   <= merge_bytes(ledg_r,   i_lsu_wdata, i_lsu_bmask);
            PAGE_HEXL: hex_lo_r <= merge_bytes(hex_lo_r, i_lsu_wdata, i_lsu_bmask);
            PAGE_HEXH: hex_hi_r <= merge_bytes(hex_hi_r, i_lsu_wdata, i_lsu_bmask);
            PAGE_LCD:  lcd_r    <= merge_bytes(lcd_r,    i_lsu_wdata, i_lsu_bmask);
            default: ;
         endcase
      end
   end

   // Registered readback; sees pre-write contents on a simultaneous store.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         rdata_r <= 32'h0;
      end else begin
         case (page_s)
            PAGE_LEDR: rdata_r <= ledr_r;
            PAGE_LEDG: rdata_r <= ledg_r;
            PAGE_HEXL: rdata_r <= hex_lo_r;
            PAGE_HEXH: rdata_r <= hex_hi_r;
            PAGE_LCD:  rdata_r <= lcd_r;
            default:   rdata_r <= 32'h0;
         endcase
      end
   end

   assign pre_wrap_s = (pre_r == PRE_LAST);

   // Scan prescaler and digit index; the blank cycle is part of each digit period.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         pre_r   <= '0;
         idx_r   <= 3'd0;
         state_r <= BLANK;
      end else begin
         state_r <= state_s;
         if (pre_wrap_s) begin
            pre_r <= '0;
            idx_r <= (idx_r == IDX_LAST) ? 3'd0 : idx_r + 3'd1;
         end else begin
            pre_r <= pre_r + PRE_W'(1);
         end
      end
   end

   // Scan FSM next state.
   always_comb begin
      state_s = state_r;
      case (state_r)
         BLANK:   state_s = ACTIVE;
         ACTIVE:  state_s = pre_wrap_s ? BLANK : ACTIVE;
         default: state_s = BLANK;
      endcase
   end

   assign hex_all_s    = {hex_hi_r, hex_lo_r};
   assign digit_byte_s = hex_all_s[{idx_r, 3'b000} +: 8];

`ifdef HEX_DECODE_EN
   assign seg_s    = digit_byte_s[4] ? 7'h7F : hex_glyph(digit_byte_s[3:0]);
   assign unused_s = ^{i_lsu_addr[11:0], digit_byte_s[7:5]};
`else
   assign seg_s    = digit_byte_s[6:0];
   assign unused_s = ^{i_lsu_addr[11:0], digit_byte_s[7], hex_glyph(4'h0)};
`endif

   // Display drive from the scan state; blank forces every anode and segment off.
   always_comb begin
      o_io_an  = '1;
      o_io_hex = 7'h7F;
      if (state_r == ACTIVE) begin
         o_io_an  = ~(NUM_DIGITS'(1) << idx_r);
         o_io_hex = seg_s;
      end else begin
         o_io_an  = '1;
         o_io_hex = 7'h7F;
      end
   end

   assign o_io_rdata = rdata_r;
   assign o_io_ledr  = ledr_r;
   assign o_io_ledg  = ledg_r;
   assign o_io_lcd   = lcd_r;

endmodule
